// File: rtl/approx_err_pkg.sv
// Shared types, LFSR constants and the error-distance helper for the approximate-adder error monitor.
package approx_err_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  localparam int LFSR_W = 64;
  // x^64 + x^63 + x^61 + x^60 + 1, expressed as bit indices of a left-shifting register
  localparam int TAP_A = 63;
  localparam int TAP_B = 62;
  localparam int TAP_C = 60;
  localparam int TAP_D = 59;
  localparam logic [LFSR_W-1:0] SEED_DEFAULT = 64'd1;

  function automatic logic [31:0] ed_abs(input logic [31:0] a, input logic [31:0] b);
    return (a > b) ? (a - b) : (b - a);
  endfunction

endpackage

// File: rtl/err_lfsr64.sv
// 64-bit Fibonacci LFSR operand source; an all-zero load value is replaced by the default seed.
module err_lfsr64
  import approx_err_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [LFSR_W-1:0] load_val,
  input  logic              advance,
  output logic [LFSR_W-1:0] state
);

  logic fb;

  assign fb = state[TAP_A] ^ state[TAP_B] ^ state[TAP_C] ^ state[TAP_D];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= SEED_DEFAULT;
    end else if (load) begin
      state <= (load_val == '0) ? SEED_DEFAULT : load_val;
    end else if (advance) begin
      state <= {state[LFSR_W-2:0], fb};
    end
  end

endmodule

// File: rtl/approx_adder_err_monitor.sv
// Error-characterisation engine: issues LFSR operands, aligns the exact sum with the external adder result
// and accumulates error statistics. Optional ERR_MON_SQ_EN adds the sum_sq_ed (squared-distance) output.
//
//   state | meaning
//   IDLE  | after reset, waiting for start
//   RUN   | issuing operand pairs until num_samples have gone out
//   DRAIN | waiting for in-flight samples to be scored
//   DONE  | results final and held until the next start
module approx_adder_err_monitor
  import approx_err_pkg::*;
#(
  parameter int N   = 16,
  parameter int LAT = 0,
  parameter int CW  = 24
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            pause,
  input  logic [CW-1:0]   num_samples,
  input  logic [63:0]     seed,
  output logic [N-1:0]    op_a,
  output logic [N-1:0]    op_b,
  output logic            op_valid,
  input  logic [N-1:0]    res_approx,
  output logic            busy,
  output logic            done,
  output logic [CW-1:0]   err_count,
  output logic [N+CW-1:0] sum_ed,
  output logic [N-1:0]    max_ed,
  output logic [CW-1:0]   samples
`ifdef ERR_MON_SQ_EN
  ,
  output logic [2*N+CW-1:0] sum_sq_ed
`endif
);

  localparam int SW = N + CW;

  state_t              state;
  logic [CW-1:0]       issued;
  logic [CW-1:0]       num_latched;
  logic [N-1:0]        exact_q;
  logic [LFSR_W-1:0]   lfsr_q;
  logic                start_run;
  logic                issue;
  logic                al_valid;
  logic [N-1:0]        al_exact;
  logic                pipe_busy;
  logic                drain_busy;
  logic [N-1:0]        ed;
  logic                unused_lfsr;

  assign start_run   = start && ((state == IDLE) || (state == DONE));
  assign issue       = (state == RUN) && !pause && (issued < num_latched);
  assign unused_lfsr = ^lfsr_q;

  err_lfsr64 u_lfsr (
    .clk      (clk),
    .rst      (rst),
    .load     (start_run),
    .load_val (seed),
    .advance  (issue),
    .state    (lfsr_q)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      busy        <= 1'b0;
      done        <= 1'b0;
      op_valid    <= 1'b0;
      op_a        <= '0;
      op_b        <= '0;
      exact_q     <= '0;
      issued      <= '0;
      num_latched <= '0;
    end else begin
      op_valid <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state       <= RUN;
            busy        <= 1'b1;
            done        <= 1'b0;
            issued      <= '0;
            num_latched <= num_samples;
          end
        end
        RUN: begin
          if (issue) begin
            op_valid <= 1'b1;
            op_a     <= lfsr_q[N-1:0];
            op_b     <= lfsr_q[2*N-1:N];
            exact_q  <= lfsr_q[N-1:0] + lfsr_q[2*N-1:N];
            issued   <= issued + 1'b1;
          end else if (issued == num_latched) begin
            state <= DRAIN;
          end
        end
        DRAIN: begin
          if (!drain_busy) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Exact sum and valid ride alongside the external adder so res_approx is scored against its own operands
  if (LAT == 0) begin : g_no_dly
    assign al_valid  = op_valid;
    assign al_exact  = exact_q;
    assign pipe_busy = op_valid;
  end else begin : g_dly
    logic [LAT-1:0] v_sr;
    logic [N-1:0]   e_sr [LAT];

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        v_sr <= '0;
        for (int i = 0; i < LAT; i++) e_sr[i] <= '0;
      end else begin
        v_sr[0] <= op_valid;
        e_sr[0] <= exact_q;
        for (int i = 1; i < LAT; i++) begin
          v_sr[i] <= v_sr[i-1];
          e_sr[i] <= e_sr[i-1];
        end
      end
    end

    assign al_valid  = v_sr[LAT-1];
    assign al_exact  = e_sr[LAT-1];
    assign pipe_busy = op_valid | (|v_sr);
  end

  assign ed = N'(ed_abs(32'(res_approx), 32'(al_exact)));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      samples   <= '0;
      err_count <= '0;
      sum_ed    <= '0;
      max_ed    <= '0;
    end else if (start_run) begin
      samples   <= '0;
      err_count <= '0;
      sum_ed    <= '0;
      max_ed    <= '0;
    end else if (al_valid) begin
      samples   <= samples + 1'b1;
      err_count <= err_count + CW'(ed != '0);
      sum_ed    <= sum_ed + SW'(ed);
      if (ed > max_ed) max_ed <= ed;
    end
  end

`ifdef ERR_MON_SQ_EN
  localparam int QW = 2 * N + CW;

  logic           sq_valid;
  logic [2*N-1:0] sq_q;

  // Product is registered once before accumulation, so the drain also waits on this stage
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sq_valid  <= 1'b0;
      sq_q      <= '0;
      sum_sq_ed <= '0;
    end else begin
      sq_valid <= al_valid;
      sq_q     <= (2*N)'(ed) * (2*N)'(ed);
      if (start_run) begin
        sum_sq_ed <= '0;
      end else if (sq_valid) begin
        sum_sq_ed <= sum_sq_ed + QW'(sq_q);
      end
    end
  end

  assign drain_busy = pipe_busy | sq_valid;
`else
  assign drain_busy = pipe_busy;
`endif

endmodule

// File: tb/tb_approx_adder_err_monitor.sv
// Directed bench for approx_adder_err_monitor: one LAT=0 and one LAT=3 instance, each fed by a behavioural adder model.
module tb_approx_adder_err_monitor;

  localparam int N  = 16;
  localparam int CW = 24;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int ncomp = 0;
  int nfail = 0;

  // instance u0: LAT=0
  logic          start0, pause0, v0, busy0, done0;
  logic [CW-1:0] num0, errc0, smp0;
  logic [63:0]   seed0;
  logic [N-1:0]  a0, b0, res0, med0;
  logic [N+CW-1:0] sed0;
  // instance u3: LAT=3
  logic          start3, pause3, v3, busy3, done3;
  logic [CW-1:0] num3, errc3, smp3;
  logic [63:0]   seed3;
  logic [N-1:0]  a3, b3, res3, med3;
  logic [N+CW-1:0] sed3;
`ifdef ERR_MON_SQ_EN
  logic [2*N+CW-1:0] ssq0, ssq3;
`endif

  int mode0, mode3;
  logic [N-1:0] p3 [3];
  logic [31:0]  q0 [$];

  approx_adder_err_monitor #(.N(N), .LAT(0), .CW(CW)) u0 (
    .clk(clk), .rst(rst), .start(start0), .pause(pause0), .num_samples(num0), .seed(seed0),
    .op_a(a0), .op_b(b0), .op_valid(v0), .res_approx(res0), .busy(busy0), .done(done0),
    .err_count(errc0), .sum_ed(sed0), .max_ed(med0), .samples(smp0)
`ifdef ERR_MON_SQ_EN
    , .sum_sq_ed(ssq0)
`endif
  );

  approx_adder_err_monitor #(.N(N), .LAT(3), .CW(CW)) u3 (
    .clk(clk), .rst(rst), .start(start3), .pause(pause3), .num_samples(num3), .seed(seed3),
    .op_a(a3), .op_b(b3), .op_valid(v3), .res_approx(res3), .busy(busy3), .done(done3),
    .err_count(errc3), .sum_ed(sed3), .max_ed(med3), .samples(smp3)
`ifdef ERR_MON_SQ_EN
    , .sum_sq_ed(ssq3)
`endif
  );

  function automatic logic [N-1:0] approx_f(input int mode, input logic [N-1:0] a, input logic [N-1:0] b);
    logic [N-1:0] e;
    e = a + b;
    case (mode)
      1:       return e ^ 16'h0001;
      2:       return e & 16'hFF00;
      default: return e;
    endcase
  endfunction

  assign res0 = approx_f(mode0, a0, b0);

  // three-cycle adder model for u3
  always @(posedge clk) begin
    p3[0] <= approx_f(mode3, a3, b3);
    p3[1] <= p3[0];
    p3[2] <= p3[1];
  end
  assign res3 = p3[2];

  always @(negedge clk) if (v0) q0.push_back({b0, a0});

  function automatic logic [63:0] lnext(input logic [63:0] l);
    return {l[62:0], l[63] ^ l[62] ^ l[60] ^ l[59]};
  endfunction

  function automatic logic [31:0] model_op(input logic [63:0] sd, input int k);
    logic [63:0] l;
    l = (sd == 64'd0) ? 64'd1 : sd;
    for (int i = 0; i < k; i++) l = lnext(l);
    return l[31:0];
  endfunction

  task automatic model_run(input logic [63:0] sd, input int n, input int mode,
                           output longint s, output int mx, output int ec);
    logic [63:0]  l;
    logic [N-1:0] e, r, d;
    l = (sd == 64'd0) ? 64'd1 : sd;
    s = 0; mx = 0; ec = 0;
    for (int k = 0; k < n; k++) begin
      e = l[15:0] + l[31:16];
      r = approx_f(mode, l[15:0], l[31:16]);
      d = (r > e) ? r - e : e - r;
      s = s + longint'(d);
      if (int'(d) > mx) mx = int'(d);
      if (d != 0) ec++;
      l = lnext(l);
    end
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    ncomp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic pulse_start(input int sel, input int n, input logic [63:0] sd);
    @(negedge clk);
    if (sel == 0) begin num0 = CW'(n); seed0 = sd; start0 = 1'b1; end
    else          begin num3 = CW'(n); seed3 = sd; start3 = 1'b1; end
    @(negedge clk);
    start0 = 1'b0;
    start3 = 1'b0;
  endtask

  task automatic wait_done(input int sel, input int budget, input bit pz, output int cyc, output int bcyc);
    cyc = 0;
    bcyc = 0;
    while (1) begin
      if ((sel == 0) ? done0 : done3) break;
      if ((sel == 0) ? busy0 : busy3) bcyc++;
      if (cyc >= budget) begin
        ncomp++;
        nfail++;
        $error("FAIL done_timeout: observed no done after %0d cycles expected done", cyc);
        break;
      end
      if (pz) pause0 = (((cyc / 4) % 2) == 1);
      @(negedge clk);
      cyc++;
    end
    pause0 = 1'b0;
  endtask

  initial begin
    int cyc, bcyc, mx, ec;
    longint s;
    logic [31:0] t;

    rst = 1'b1;
    start0 = 1'b0; pause0 = 1'b0; num0 = '0; seed0 = '0; mode0 = 0;
    start3 = 1'b0; pause3 = 1'b0; num3 = '0; seed3 = '0; mode3 = 1;
    repeat (3) @(negedge clk);
    check("rst_busy_done", {busy0, done0, busy3, done3}, 0);
    check("rst_ops", {a0, b0, v0}, 0);
    check("rst_acc", {smp0, errc0, med0}, 0);
    check("rst_sum", sed0, 0);
    rst = 1'b0;

    // exact adder, LAT=0, 1000 samples
    pulse_start(0, 1000, 64'h1);
    check("run_busy", busy0, 1);
    wait_done(0, 3000, 1'b0, cyc, bcyc);
    check("exact_cycles", cyc, 1002);
    check("exact_samples", smp0, 1000);
    check("exact_err", errc0, 0);
    check("exact_sum", sed0, 0);
    check("exact_max", med0, 0);
    check("exact_busy_low", busy0, 0);
    check("exact_opcount", q0.size(), 1000);
    check("exact_op0", q0[0], 32'h0000_0001);
    t = model_op(64'h1, 999);
    check("exact_op999", q0[999], t);
    check("exact_hold_a", a0, t[15:0]);
    check("exact_hold_v", v0, 0);

    // exact^1, LAT=3
    pulse_start(3, 500, 64'hBEEF);
    wait_done(3, 2000, 1'b0, cyc, bcyc);
    check("lat3_cycles", cyc, 505);
    check("lat3_samples", smp3, 500);
    check("lat3_err", errc3, 500);
    check("lat3_sum", sed3, 500);
    check("lat3_max", med3, 1);

    // truncated low byte, seed 0xACE1
    mode0 = 2;
    q0.delete();
    pulse_start(0, 300, 64'hACE1);
    wait_done(0, 1000, 1'b0, cyc, bcyc);
    model_run(64'hACE1, 300, 2, s, mx, ec);
    check("trunc_sum", sed0, s);
    check("trunc_max", med0, mx);
    check("trunc_err", errc0, ec);
    check("trunc_max_le_255", med0 <= 16'd255, 1);
    check("trunc_op0", q0[0], model_op(64'hACE1, 0));

    // same run with and without pause
    model_run(64'h5EED, 100, 2, s, mx, ec);
    pulse_start(0, 100, 64'h5EED);
    wait_done(0, 1000, 1'b0, cyc, bcyc);
    check("nopause_samples", smp0, 100);
    check("nopause_sum", sed0, s);
    check("nopause_max", med0, mx);
    check("nopause_err", errc0, ec);
    pulse_start(0, 100, 64'h5EED);
    wait_done(0, 1000, 1'b1, cyc, bcyc);
    check("pause_samples", smp0, 100);
    check("pause_sum", sed0, s);
    check("pause_max", med0, mx);
    check("pause_err", errc0, ec);
    check("pause_stretched", cyc > 102, 1);

    // zero-length run
    q0.delete();
    pulse_start(0, 0, 64'h1234);
    wait_done(0, 100, 1'b0, cyc, bcyc);
    check("zero_busy_cycles", bcyc, 2);
    check("zero_done", done0, 1);
    check("zero_acc", {smp0, errc0, med0}, 0);
    check("zero_sum", sed0, 0);
    check("zero_noops", q0.size(), 0);

    // seed 0 behaves as seed 1
    mode0 = 0;
    pulse_start(0, 4, 64'h0);
    wait_done(0, 100, 1'b0, cyc, bcyc);
    check("seed0_opcount", q0.size(), 4);
    for (int k = 0; k < 4; k++) check($sformatf("seed0_op%0d", k), q0[k], model_op(64'h1, k));

    // reset mid-run at sample 37
    pulse_start(3, 200, 64'h7);
    cyc = 0;
    while (smp3 != 24'd37 && cyc < 500) begin
      @(negedge clk);
      cyc++;
    end
    check("abort_reached_37", smp3, 37);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("abort_busy_done", {busy3, done3}, 0);
    check("abort_ops", {a3, b3, v3}, 0);
    check("abort_acc", {smp3, errc3, med3}, 0);
    check("abort_sum", sed3, 0);
    @(negedge clk);
    rst = 1'b0;

    // clean rerun; a second start while busy is ignored
    pulse_start(3, 20, 64'h9);
    repeat (3) @(negedge clk);
    pulse_start(3, 5, 64'h55);
    check("restart_still_busy", busy3, 1);
    wait_done(3, 200, 1'b0, cyc, bcyc);
    check("restart_samples", smp3, 20);
    check("restart_err", errc3, 20);
    check("restart_sum", sed3, 20);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncomp, nfail);
    $finish;
  end

endmodule

// File: doc/approx_adder_err_monitor.md
Name: approx_adder_err_monitor

Overview:
- Synthesizable, on-chip error-characterisation engine for approximate adders (CPETA and similar).
- Generates pseudo-random operand pairs, drives them to an external approximate adder with fixed pipeline latency, and computes the exact sum internally.
- Accumulates error count, total error distance and maximum error distance in hardware. Host computes ER/MED/NMED from the results.
- Runs at silicon speed instead of simulation speed.

Parameters:
- N, 16, operand/sum width; legal range 4..32.
- LAT, 0, approximate-adder latency in cycles from op_valid/op_a/op_b to res_approx; legal range 0..8.
- CW, 24, sample-counter width; max run length is 2^CW-1.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  pulse; begins a run from IDLE or DONE.
- pause  in  1  level; suppresses new operand issue while high.
- num_samples  in  CW  run length; sampled on start.
- seed  in  64  LFSR seed; sampled on start.
- op_a  out  N  operand A to the approximate adder.
- op_b  out  N  operand B to the approximate adder.
- op_valid  out  1  op_a/op_b valid this cycle.
- res_approx  in  N  approximate sum; scored exactly LAT cycles after the matching op_valid.
- busy  out  1  high in RUN or DRAIN.
- done  out  1  high in DONE.
- err_count  out  CW  number of samples with res_approx != exact.
- sum_ed  out  N+CW  sum of error distances.
- max_ed  out  N  largest error distance seen.
- samples  out  CW  number of samples scored.

Behaviour:
- Reset: state=IDLE; all outputs 0; LFSR=1. Reset asserted mid-run aborts immediately; no partial results are kept.
- FSM states: IDLE, RUN, DRAIN, DONE.
  - IDLE/DONE + start → RUN. On that edge: LFSR loads seed (seed==0 is replaced by 1); num_samples is latched; accumulators, issue counter and samples are cleared.
  - start while busy is ignored.
  - RUN → DRAIN when issued==num_latched, including num_samples==0. num_samples==0 gives a DONE run with all-zero results.
  - DRAIN → DONE when the in-flight valid shift register is empty. With LAT=0, DRAIN lasts exactly 1 cycle.
  - DONE holds results until the next start.
- Issue: in RUN with pause=0 and issued<num_latched:
  - op_valid=1; op_a=lfsr[N-1:0]; op_b=lfsr[2N-1:N].
  - LFSR advances and issued increments.
  - Otherwise op_valid=0 and op_a/op_b hold their values.
  - Outputs are registered.
- LFSR: 64-bit Fibonacci, x^64+x^63+x^61+x^60+1, shifts left, feedback into bit 0.
- Scoring pipeline:
  - exact = (op_a+op_b) mod 2^N, computed at issue.
  - exact and valid are delayed through LAT register stages, aligned with res_approx.
  - A scored sample has ed = |res_approx − exact| as N-bit unsigned.
  - Per scored sample: samples+=1; err_count+=(ed!=0); sum_ed+=ed; max_ed=max(max_ed,ed).
  - Accumulators update on the clock edge after the aligned valid; results are final when done rises.
- Pause does not stall in-flight samples; the pipeline always drains.
- No overflow handling is needed: the widths are sufficient by construction.

Optional Feature:
- Macro ERR_MON_SQ_EN.
- Defined: adds output sum_sq_ed (2N+CW bits), the accumulated ed*ed used for MSE. The ed*ed product is registered one extra stage, so the DRAIN exit condition includes that stage. sum_sq_ed resets to 0 and clears on start.
- Undefined: no port, no multiplier; DRAIN timing is as above.

Decomposition:
- Package approx_err_pkg:
  - state enum (IDLE, RUN, DRAIN, DONE).
  - LFSR width 64, tap constants, nonzero seed default.
  - ed_abs function.
- Sub-module err_lfsr64 (load, advance, state out).
- Delay line and accumulators stay in the top module.

Test Plan:
- Exact-adder model, N=16, LAT=0, num_samples=1000, seed=0x1 → err_count=0, sum_ed=0, max_ed=0, samples=1000, done after 1002 cycles.
- Model res=exact^1, LAT=3, num_samples=500 → err_count=500, sum_ed=500, max_ed=1. The model's result must be checked 3 cycles after each op_valid.
- Model res=exact&~0xFF, N=16 → max_ed≤255; sum_ed equals a reference-model sum over the same LFSR sequence starting from seed 0xACE1.
- pause toggled high every other 4 cycles, num_samples=100 → samples=100, identical results to the unpaused run with the same seed.
- num_samples=0 → busy for 2 cycles (RUN, DRAIN), done=1, all counters 0. seed=0 with num_samples=4 → operands are the same as with seed=1.
- rst asserted mid-RUN at sample 37 → next cycle all outputs 0, IDLE. The next start runs cleanly; start pulsed while busy has no effect.
